// File: rtl/mel_cycle_sequencer.sv
// Runs one MEL actuation cycle (ENABLE, INT pulse, OPEN/ACK wait, hold, release, HOME check)
// and reports a result code plus INT-to-ACK latency. All state and outputs are registered.
module mel_cycle_sequencer #(
    parameter int CNT_W = 16,
    parameter int LAT_W = 32
) (
    input  logic             SYSCLK,
    input  logic             OPB_RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] INT_DELAY,
    input  logic [CNT_W-1:0] INT_WIDTH,
    input  logic [CNT_W-1:0] OPEN_TIMEOUT,
    input  logic [CNT_W-1:0] ACK_TIMEOUT,
    input  logic [CNT_W-1:0] HOLD_TIME,
    input  logic [CNT_W-1:0] REL_TIMEOUT,
    input  logic [CNT_W-1:0] ERR_RST_WIDTH,
    input  logic [2:0]       CTRL_STATE,
    input  logic             MEL_ACK_IN,
    input  logic             MEL_ERROR,
    output logic             MEL_ENABLE_OUT,
    output logic             MEL_INT_OUT,
    output logic             ERROR_RESET,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       RESULT,
    output logic [LAT_W-1:0] LATENCY
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_INTP, S_WOPEN, S_WACK, S_HOLD, S_REL, S_ERST, S_FIN
    } state_t;

    localparam logic [2:0] RES_PASS    = 3'd0;
    localparam logic [2:0] RES_OPEN_TO = 3'd1;
    localparam logic [2:0] RES_ACK_TO  = 3'd2;
    localparam logic [2:0] RES_MEL_ERR = 3'd3;
    localparam logic [2:0] RES_ABORTED = 3'd4;
    localparam logic [2:0] RES_REL_TO  = 3'd5;

    localparam logic [2:0] CS_HOME  = 3'd0;
    localparam logic [2:0] CS_OPEN  = 3'd1;
    localparam logic [2:0] CS_NOACK = 3'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [2:0]       result_q, result_d, fault_code;
    logic             en_q, en_d, int_q, int_d, erst_q, erst_d, done_q, done_d;
    logic             lat_run_q, lat_run_d;
    logic             fault, active;

    // One shared phase timer; it saturates so a huge timeout config never wraps into an early fault.
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign active    = state_q inside {S_SETUP, S_INTP, S_WOPEN, S_WACK, S_HOLD, S_REL};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lat_d      = lat_q;
        lat_run_d  = lat_run_q;
        result_d   = result_q;
        en_d       = en_q;
        int_d      = int_q;
        erst_d     = erst_q;
        done_d     = 1'b0;
        fault      = 1'b0;
        fault_code = RES_PASS;

        if (lat_run_q) begin
            if (MEL_ACK_IN) begin
                lat_run_d = 1'b0;
            end else if (!(&lat_q)) begin
                lat_d = lat_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d   = S_SETUP;
                    en_d      = 1'b1;
                    timer_d   = '0;
                    result_d  = RES_PASS;
                    lat_d     = '0;
                    lat_run_d = 1'b0;
                end
            end
            S_SETUP: begin
                timer_d = timer_inc;
                if (timer_inc >= INT_DELAY) begin
                    state_d   = S_INTP;
                    int_d     = 1'b1;
                    timer_d   = '0;
                    lat_d     = {{(LAT_W-1){1'b0}}, 1'b1};
                    lat_run_d = 1'b1;
                end
            end
            S_INTP: begin
                // Timer keeps running through WOPEN: the OPEN timeout is measured from INT rise.
                timer_d = timer_inc;
                if (timer_inc >= INT_WIDTH) begin
                    int_d   = 1'b0;
                    state_d = S_WOPEN;
                end
            end
            S_WOPEN: begin
                timer_d = timer_inc;
                if (CTRL_STATE == CS_OPEN) begin
                    state_d = S_WACK;
                    timer_d = '0;
                end else if (timer_inc > OPEN_TIMEOUT) begin
                    fault      = 1'b1;
                    fault_code = RES_OPEN_TO;
                end
            end
            S_WACK: begin
                timer_d = timer_inc;
                if (MEL_ACK_IN) begin
                    state_d = S_HOLD;
                    timer_d = '0;
                end else if (CTRL_STATE == CS_NOACK || timer_inc > ACK_TIMEOUT) begin
                    fault      = 1'b1;
                    fault_code = RES_ACK_TO;
                end
            end
            S_HOLD: begin
                timer_d = timer_inc;
                if (timer_inc >= HOLD_TIME) begin
                    en_d    = 1'b0;
                    state_d = S_REL;
                    timer_d = '0;
                end
            end
            S_REL: begin
                timer_d = timer_inc;
                if (CTRL_STATE == CS_HOME) begin
                    result_d = RES_PASS;
                    state_d  = S_FIN;
                    done_d   = 1'b1;
                end else if (timer_inc > REL_TIMEOUT) begin
                    fault      = 1'b1;
                    fault_code = RES_REL_TO;
                end
            end
            S_ERST: begin
                timer_d = timer_inc;
                if (timer_inc >= ERR_RST_WIDTH) begin
                    erst_d  = 1'b0;
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outranks a MEL error, which outranks anything the phase logic decided this cycle.
        if (active && ABORT) begin
            fault      = 1'b1;
            fault_code = RES_ABORTED;
        end else if (active && MEL_ERROR) begin
            fault      = 1'b1;
            fault_code = RES_MEL_ERR;
        end

        if (fault) begin
            en_d      = 1'b0;
            int_d     = 1'b0;
            result_d  = fault_code;
            lat_d     = lat_q;
            lat_run_d = 1'b0;
            timer_d   = '0;
            if (fault_code == RES_ABORTED) begin
                state_d = S_FIN;
                done_d  = 1'b1;
                erst_d  = 1'b0;
            end else begin
                state_d = S_ERST;
                erst_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (OPB_RST) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            lat_q     <= '0;
            lat_run_q <= 1'b0;
            result_q  <= RES_PASS;
            en_q      <= 1'b0;
            int_q     <= 1'b0;
            erst_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lat_q     <= lat_d;
            lat_run_q <= lat_run_d;
            result_q  <= result_d;
            en_q      <= en_d;
            int_q     <= int_d;
            erst_q    <= erst_d;
            done_q    <= done_d;
        end
    end

    assign MEL_ENABLE_OUT = en_q;
    assign MEL_INT_OUT    = int_q;
    assign ERROR_RESET    = erst_q;
    assign BUSY           = (state_q != S_IDLE);
    assign DONE           = done_q;
    assign RESULT         = result_q;
    assign LATENCY        = lat_q;

endmodule

// File: tb/tb_mel_cycle_sequencer.sv
// Self-checking bench: an event-time model predicts every output for every cycle of each MEL cycle.
module tb_mel_cycle_sequencer;

    localparam int CNT_W = 16;
    localparam int LAT_W = 8;
    localparam int BIG   = 1 << 28;
    localparam int NEVER = 100000;

    logic             SYSCLK = 1'b0;
    logic             OPB_RST = 1'b1, START = 1'b0, ABORT = 1'b0;
    logic [CNT_W-1:0] INT_DELAY = '0, INT_WIDTH = '0, OPEN_TIMEOUT = '0, ACK_TIMEOUT = '0;
    logic [CNT_W-1:0] HOLD_TIME = '0, REL_TIMEOUT = '0, ERR_RST_WIDTH = '0;
    logic [2:0]       CTRL_STATE = '0;
    logic             MEL_ACK_IN = 1'b0, MEL_ERROR = 1'b0;
    logic             MEL_ENABLE_OUT, MEL_INT_OUT, ERROR_RESET, BUSY, DONE;
    logic [2:0]       RESULT;
    logic [LAT_W-1:0] LATENCY;

    mel_cycle_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
        .SYSCLK(SYSCLK), .OPB_RST(OPB_RST), .START(START), .ABORT(ABORT),
        .INT_DELAY(INT_DELAY), .INT_WIDTH(INT_WIDTH), .OPEN_TIMEOUT(OPEN_TIMEOUT),
        .ACK_TIMEOUT(ACK_TIMEOUT), .HOLD_TIME(HOLD_TIME), .REL_TIMEOUT(REL_TIMEOUT),
        .ERR_RST_WIDTH(ERR_RST_WIDTH), .CTRL_STATE(CTRL_STATE), .MEL_ACK_IN(MEL_ACK_IN),
        .MEL_ERROR(MEL_ERROR), .MEL_ENABLE_OUT(MEL_ENABLE_OUT), .MEL_INT_OUT(MEL_INT_OUT),
        .ERROR_RESET(ERROR_RESET), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .LATENCY(LATENCY)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario: config plus input event offsets (in clock edges).
    int s_delay, s_width, s_ot, s_at, s_hold, s_rt, s_erw;
    int s_open_off, s_ack_off, s_noack_off, s_home_off, s_me, s_ab, s_dup;

    // Model results: edge numbers counted from the edge that samples START (edge 0).
    int m_d, m_w, m_we, m_oe, m_ae, m_re, m_tn, m_cn, m_F, m_code, m_en_end, m_stop, m_done;
    bit m_noack, m_erst;

    int cyc;
    bit chk_en = 1'b0;
    int en_cnt, int_cnt, erst_cnt, done_cnt, done_at;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Which event ends the cycle, and on which edge, straight from the phase rules.
    function automatic void build_model();
        int lim;
        m_d  = imax(s_delay, 1);
        m_w  = imax(s_width, 1);
        m_we = imax(s_erw, 1);
        m_oe = m_d + s_open_off;
        m_ae = m_oe + s_ack_off;
        m_noack = (s_noack_off != 0) && (s_noack_off < s_ack_off);
        m_re = BIG;
        if (s_open_off > s_ot + 1) begin
            m_tn = m_d + s_ot + 1;
            m_cn = 1;
        end else begin
            lim = s_at + 1;
            if (m_noack && s_noack_off < lim) lim = s_noack_off;
            if (s_ack_off <= lim) begin
                m_re = m_ae + imax(s_hold, 1);
                if (s_home_off <= s_rt + 1) begin
                    m_tn = m_re + s_home_off;
                    m_cn = 0;
                end else begin
                    m_tn = m_re + s_rt + 1;
                    m_cn = 5;
                end
            end else begin
                m_tn = m_oe + lim;
                m_cn = 2;
            end
        end
        if (s_ab != 0 && s_ab <= m_tn && (s_me == 0 || s_ab <= s_me)) begin
            m_F = s_ab;  m_code = 4;
        end else if (s_me != 0 && s_me <= m_tn) begin
            m_F = s_me;  m_code = 3;
        end else begin
            m_F = m_tn;  m_code = m_cn;
        end
        m_en_end = (m_re <= m_F) ? m_re : m_F;
        m_stop   = imin(m_ae, m_F);
        m_erst   = (m_code != 0) && (m_code != 4);
        m_done   = m_erst ? m_F + m_we : m_F;
    endfunction

    task automatic drive_inputs(input int e);
        logic [2:0] c;
        START      = (e == s_dup);
        ABORT      = (e == s_ab);
        MEL_ERROR  = (e == s_me);
        MEL_ACK_IN = (e >= m_ae);
        c = 3'd0;
        if (e >= m_oe) c = 3'd1;
        if (m_noack && e >= m_oe + s_noack_off) c = 3'd3;
        if (e >= m_re) c = 3'd4;
        if (e >= m_re + s_home_off) c = 3'd0;
        CTRL_STATE = c;
    endtask

    task automatic idle_inputs();
        START = 0; ABORT = 0; MEL_ERROR = 0; MEL_ACK_IN = 0; CTRL_STATE = 3'd0;
    endtask

    task automatic set_scn(input int dl, input int wd, input int ot, input int at, input int hd,
                           input int rt, input int er, input int oo, input int ao, input int no,
                           input int ho, input int me, input int ab);
        s_delay = dl; s_width = wd; s_ot = ot; s_at = at; s_hold = hd; s_rt = rt; s_erw = er;
        s_open_off = oo; s_ack_off = ao; s_noack_off = no; s_home_off = ho; s_me = me; s_ab = ab;
        s_dup = 0;
    endtask

    task automatic run_txn(input int rst_at, input int id);
        build_model();
        INT_DELAY = CNT_W'(s_delay);   INT_WIDTH = CNT_W'(s_width);
        OPEN_TIMEOUT = CNT_W'(s_ot);   ACK_TIMEOUT = CNT_W'(s_at);
        HOLD_TIME = CNT_W'(s_hold);    REL_TIMEOUT = CNT_W'(s_rt);
        ERR_RST_WIDTH = CNT_W'(s_erw);
        @(posedge SYSCLK); #1;
        idle_inputs();
        START = 1'b1;
        @(posedge SYSCLK); #1;
        cyc = 0;
        chk_en = (rst_at < 0);
        while (cyc < m_done + 2) begin
            drive_inputs(cyc + 1);
            if (cyc + 1 == rst_at) OPB_RST = 1'b1;
            @(posedge SYSCLK); #1;
            cyc++;
            if (cyc == rst_at) break;
            if (cyc > 5000) begin
                check("cycle_budget", cyc, m_done + 2);
                break;
            end
        end
        chk_en = 1'b0;
        OPB_RST = 1'b0;
        idle_inputs();
        $display("txn %0d: result %0d end_edge %0d done_edge %0d latency %0d", id, RESULT, m_F, m_done, LATENCY);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge SYSCLK) begin
        if (chk_en) begin : cmp
            int n, v, lim;
            n = cyc;
            if (n == 0) begin
                en_cnt = 0; int_cnt = 0; erst_cnt = 0; done_cnt = 0; done_at = -1;
            end
            check("enable",  MEL_ENABLE_OUT, (n < m_en_end) ? 1 : 0);
            check("int",     MEL_INT_OUT, (n >= m_d && n < imin(m_d + m_w, m_F)) ? 1 : 0);
            check("err_rst", ERROR_RESET, (m_erst && n >= m_F && n < m_F + m_we) ? 1 : 0);
            check("done",    DONE, (n == m_done) ? 1 : 0);
            check("busy",    BUSY, (n <= m_done) ? 1 : 0);
            check("result",  RESULT, (n < m_F) ? 0 : m_code);
            if (n < m_d) v = 0;
            else begin
                v = n - m_d + 1;
                lim = m_stop - m_d;
                if (v > lim) v = lim;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
            end
            check("latency", LATENCY, v);
            en_cnt   += int'(MEL_ENABLE_OUT);
            int_cnt  += int'(MEL_INT_OUT);
            erst_cnt += int'(ERROR_RESET);
            done_cnt += int'(DONE);
            if (DONE) done_at = n;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        repeat (3) @(posedge SYSCLK);
        #1;
        check("rst_enable", MEL_ENABLE_OUT, 0);
        check("rst_int", MEL_INT_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_result", RESULT, 0);
        check("rst_latency", LATENCY, 0);
        OPB_RST = 1'b0;

        // Nominal cycle.
        set_scn(4, 2, 20, 30, 5, 10, 2, 10, 20, 0, 3, 0, 0);
        run_txn(-1, 1);
        check("nom_latency", LATENCY, 30);
        check("nom_enable_cycles", en_cnt, 39);
        check("nom_done_pulses", done_cnt, 1);
        check("nom_result", RESULT, 0);

        // OPEN never arrives.
        set_scn(3, 1, 50, 10, 1, 5, 3, NEVER, 5, 0, 1, 0, 0);
        run_txn(-1, 2);
        check("opento_result", RESULT, 1);
        check("opento_enable_cycles", en_cnt, 54);
        check("opento_erst_cycles", erst_cnt, 3);

        // ACK never arrives, then NOACK reported.
        set_scn(2, 1, 20, 100, 1, 5, 1, 5, NEVER, 0, 1, 0, 0);
        run_txn(-1, 3);
        check("ackto_result", RESULT, 2);
        set_scn(2, 1, 20, 100, 1, 5, 1, 5, NEVER, 4, 1, 0, 0);
        run_txn(-1, 4);
        check("noack_result", RESULT, 2);
        check("noack_enable_cycles", en_cnt, 11);

        // MEL_ERROR on the same edge as the OPEN timeout; ABORT during HOLD.
        set_scn(2, 1, 10, 10, 1, 5, 2, NEVER, 5, 0, 1, 13, 0);
        run_txn(-1, 5);
        check("melerr_result", RESULT, 3);
        set_scn(4, 2, 20, 30, 5, 10, 2, 10, 20, 0, 3, 0, 36);
        run_txn(-1, 6);
        check("abort_result", RESULT, 4);
        check("abort_erst_cycles", erst_cnt, 0);
        check("abort_done_edge", done_at, 36);

        // Zero widths, latency saturation.
        set_scn(1, 0, 20, 10, 1, 5, 0, NEVER, 5, 0, 1, 0, 0);
        run_txn(-1, 7);
        check("w0_int_cycles", int_cnt, 1);
        check("w0_erst_cycles", erst_cnt, 1);
        set_scn(1, 0, 20, 400, 0, 5, 0, 2, 300, 0, 1, 0, 0);
        run_txn(-1, 8);
        check("sat_latency", LATENCY, 255);
        check("sat_result", RESULT, 0);

        // START together with ABORT in IDLE: nothing starts.
        @(posedge SYSCLK); #1;
        START = 1'b1; ABORT = 1'b1;
        @(posedge SYSCLK); #1;
        START = 1'b0; ABORT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("startabort_busy", BUSY, 0);
            check("startabort_enable", MEL_ENABLE_OUT, 0);
            check("startabort_result", RESULT, m_code);
            @(posedge SYSCLK); #1;
        end

        // Reset while waiting for ACK.
        set_scn(4, 2, 20, 30, 5, 10, 2, 10, 20, 0, 3, 0, 0);
        run_txn(19, 9);
        check("midrst_enable", MEL_ENABLE_OUT, 0);
        check("midrst_int", MEL_INT_OUT, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_result", RESULT, 0);
        check("midrst_latency", LATENCY, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge SYSCLK); #1;
            check("midrst_done", DONE, 0);
            check("midrst_idle", BUSY, 0);
        end

        // Randomized cycles, some with duplicate START, MEL_ERROR or ABORT.
        for (int t = 0; t < 120; t++) begin
            int w;
            s_delay = int'($urandom_range(0, 6));
            s_width = int'($urandom_range(0, 4));
            w = imax(s_width, 1);
            s_ot = w + int'($urandom_range(0, 20));
            s_open_off = int'($urandom_range(w + 1, s_ot + 4));
            s_at = int'($urandom_range(0, 20));
            s_ack_off = int'($urandom_range(1, s_at + 3));
            s_noack_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s_at + 3)) : 0;
            s_hold = int'($urandom_range(0, 5));
            s_rt = int'($urandom_range(0, 10));
            s_home_off = int'($urandom_range(1, s_rt + 3));
            s_erw = int'($urandom_range(0, 4));
            s_me = 0; s_ab = 0; s_dup = 0;
            build_model();
            if ($urandom_range(0, 4) == 0) s_me = int'($urandom_range(1, m_tn + 3));
            if ($urandom_range(0, 6) == 0) s_ab = int'($urandom_range(1, m_tn + 3));
            build_model();
            if ($urandom_range(0, 2) == 0) s_dup = int'($urandom_range(1, m_F));
            run_txn(-1, 10 + t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
